// File: rtl/issue_alu_dispatch_pkg.sv
// Shared types and helpers for the issue -> ALU dispatch slice.
// Holds the pipeline pack types exchanged between issue, execute and commit.
package issue_alu_dispatch_pkg;

    localparam int ROB_ID_W = 6;

    // Micro-op handed from issue to an ALU execute unit.
    typedef struct packed {
        logic                enable;
        logic [ROB_ID_W-1:0] rob_id;
        logic [3:0]          op;
        logic [4:0]          rd;
        logic [31:0]         src1;
        logic [31:0]         src2;
    } issue_execute_pack_t;

    // Feedback from commit; a flush discards all speculative work.
    typedef struct packed {
        logic                enable;
        logic                flush;
        logic [ROB_ID_W-1:0] rob_id;
    } commit_feedback_pack_t;

    // A flush is only meaningful when the feedback packet itself is valid.
    function automatic logic is_flush(commit_feedback_pack_t fb);
        return fb.enable & fb.flush;
    endfunction

endpackage

// File: rtl/issue_alu_dispatch_if.sv
// Handshake bundle between issue, commit feedback and the ALU input FIFOs.
// master = issue/ALU side driving requests, slave = the dispatch block.
interface issue_alu_dispatch_if
    import issue_alu_dispatch_pkg::*;
#(
    parameter int ALU_NUM = 2
);

    issue_execute_pack_t   issue_alu_data_in;
    logic                  issue_alu_we;
    logic                  issue_alu_full;
    commit_feedback_pack_t commit_feedback_pack;
    issue_execute_pack_t   alu_fifo_data_out [ALU_NUM];
    logic [ALU_NUM-1:0]    alu_fifo_data_out_valid;
    logic [ALU_NUM-1:0]    alu_fifo_pop;

    modport master (
        output issue_alu_data_in,
        output issue_alu_we,
        output commit_feedback_pack,
        output alu_fifo_pop,
        input  issue_alu_full,
        input  alu_fifo_data_out,
        input  alu_fifo_data_out_valid
    );

    modport slave (
        input  issue_alu_data_in,
        input  issue_alu_we,
        input  commit_feedback_pack,
        input  alu_fifo_pop,
        output issue_alu_full,
        output alu_fifo_data_out,
        output alu_fifo_data_out_valid
    );

endinterface

// File: rtl/issue_alu_dispatch_fifo.sv
// Single ALU input FIFO: circular buffer with registered count.
// Push is refused when full (from registered count, so a same-cycle pop
// does not make room); flush empties the FIFO and drops same-cycle push/pop.
module issue_alu_fifo
    import issue_alu_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  issue_execute_pack_t          din,
    output issue_execute_pack_t          dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    issue_execute_pack_t mem_r [DEPTH];
    logic [PW-1:0]       rptr_r;
    logic [PW-1:0]       wptr_r;
    logic [CW-1:0]       count_r;
    logic                do_push_s;
    logic                do_pop_s;

    assign do_push_s = push & ~flush & (count_r != CW'(DEPTH));
    assign do_pop_s  = pop  & ~flush & (count_r != CW'(0));
    assign count     = count_r;

    // Pointer and occupancy state; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_r  <= PW'(0);
            wptr_r  <= PW'(0);
            count_r <= CW'(0);
        end else if (flush) begin
            rptr_r  <= PW'(0);
            wptr_r  <= PW'(0);
            count_r <= CW'(0);
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; deliberately not reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        dout = '0;
        if (count_r != CW'(0)) begin
            dout = mem_r[rptr_r];
        end else begin
            dout = '0;
        end
    end

endmodule

// File: rtl/issue_alu_dispatch.sv
// Dispatches ALU micro-ops from issue into ALU_NUM per-unit FIFOs.
// Target FIFO is chosen round-robin starting at rr_ptr, skipping full FIFOs.
// A commit flush empties every FIFO and restarts the round-robin at FIFO 0.
module issue_alu_dispatch
    import issue_alu_dispatch_pkg::*;
#(
    parameter int ALU_NUM    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_alu_dispatch_if.slave  bus
);

    localparam int RRW = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [RRW-1:0]     rr_ptr_r;
    logic [RRW-1:0]     rr_next_s;
    logic [RRW-1:0]     target_s;
    logic               found_s;
    logic [ALU_NUM-1:0] full_s;
    logic [ALU_NUM-1:0] push_s;
    logic [CW-1:0]      count_s [ALU_NUM];
    logic               flush_s;
    logic               accept_s;

    assign flush_s            = is_flush(bus.commit_feedback_pack);
    assign bus.issue_alu_full = &full_s;
    assign accept_s           = bus.issue_alu_we & ~(&full_s) & ~flush_s;

    // Rotating scan: first non-full FIFO at or above rr_ptr, else lowest below it.
    always_comb begin
        target_s = '0;
        found_s  = 1'b0;
        for (int j = 0; j < ALU_NUM; j++) begin
            if (!found_s && (j >= int'(rr_ptr_r)) && !full_s[j]) begin
                found_s  = 1'b1;
                target_s = RRW'(j);
            end else begin
                found_s  = found_s;
            end
        end
        for (int j = 0; j < ALU_NUM; j++) begin
            if (!found_s && (j < int'(rr_ptr_r)) && !full_s[j]) begin
                found_s  = 1'b1;
                target_s = RRW'(j);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Round-robin pointer advances to the FIFO after the one just written.
    always_comb begin
        rr_next_s = '0;
        if (ALU_NUM == 1) begin
            rr_next_s = RRW'(0);
        end else if (target_s == RRW'(ALU_NUM - 1)) begin
            rr_next_s = RRW'(0);
        end else begin
            rr_next_s = target_s + RRW'(1);
        end
    end

    // Round-robin state; cleared by reset or flush, moved only on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= RRW'(0);
        end else if (flush_s) begin
            rr_ptr_r <= RRW'(0);
        end else if (accept_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    for (genvar g = 0; g < ALU_NUM; g++) begin : g_fifo
        assign push_s[g] = accept_s & (target_s == RRW'(g));
        assign full_s[g] = (count_s[g] == CW'(FIFO_DEPTH));
        assign bus.alu_fifo_data_out_valid[g] = (count_s[g] != CW'(0));

        issue_alu_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[g]),
            .pop   (bus.alu_fifo_pop[g]),
            .flush (flush_s),
            .din   (bus.issue_alu_data_in),
            .dout  (bus.alu_fifo_data_out[g]),
            .count (count_s[g])
        );
    end

endmodule

// File: tb/tb_issue_alu_dispatch.sv
// Bench for issue_alu_dispatch: a two-ALU instance and a single-ALU instance,
// directed scenarios plus random traffic checked against a queue-based model.
module tb_issue_alu_dispatch;
    import issue_alu_dispatch_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    issue_alu_dispatch_if #(.ALU_NUM(2)) if2 ();
    issue_alu_dispatch_if #(.ALU_NUM(1)) if1 ();

    issue_alu_dispatch #(.ALU_NUM(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );
    issue_alu_dispatch #(.ALU_NUM(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    // Reference contents: one queue per FIFO, plus the round-robin start index.
    issue_execute_pack_t m2_q [2][$];
    issue_execute_pack_t m1_q [$];
    int                  m2_rr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic issue_execute_pack_t mk(int rob);
        issue_execute_pack_t p;
        p        = '0;
        p.enable = 1'b1;
        p.rob_id = ROB_ID_W'(rob);
        p.op     = 4'($urandom);
        p.rd     = 5'($urandom);
        p.src1   = $urandom;
        p.src2   = $urandom;
        return p;
    endfunction

    function automatic void model_clear();
        m2_q[0].delete();
        m2_q[1].delete();
        m1_q.delete();
        m2_rr = 0;
    endfunction

    // Two-ALU model: fullness judged before this cycle's pops.
    function automatic void model2_update();
        bit fl;
        bit fullv [2];
        int tgt;
        fl  = if2.commit_feedback_pack.enable && if2.commit_feedback_pack.flush;
        tgt = -1;
        for (int i = 0; i < 2; i++) fullv[i] = (m2_q[i].size() == DEPTH);
        if (fl) begin
            m2_q[0].delete();
            m2_q[1].delete();
            m2_rr = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (tgt < 0 && !fullv[(m2_rr + k) % 2]) tgt = (m2_rr + k) % 2;
            end
            for (int i = 0; i < 2; i++) begin
                if (if2.alu_fifo_pop[i] && m2_q[i].size() > 0) void'(m2_q[i].pop_front());
            end
            if (if2.issue_alu_we && tgt >= 0) begin
                m2_q[tgt].push_back(if2.issue_alu_data_in);
                m2_rr = (tgt + 1) % 2;
            end
        end
    endfunction

    function automatic void model1_update();
        bit fl;
        bit fullv;
        fl    = if1.commit_feedback_pack.enable && if1.commit_feedback_pack.flush;
        fullv = (m1_q.size() == DEPTH);
        if (fl) begin
            m1_q.delete();
        end else begin
            if (if1.alu_fifo_pop[0] && m1_q.size() > 0) void'(m1_q.pop_front());
            if (if1.issue_alu_we && !fullv) m1_q.push_back(if1.issue_alu_data_in);
        end
    endfunction

    task automatic step();
        model2_update();
        model1_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        if2.issue_alu_we         = 1'b0;
        if2.issue_alu_data_in    = '0;
        if2.alu_fifo_pop         = 2'b00;
        if2.commit_feedback_pack = '0;
        if1.issue_alu_we         = 1'b0;
        if1.issue_alu_data_in    = '0;
        if1.alu_fifo_pop         = 1'b0;
        if1.commit_feedback_pack = '0;
    endtask

    task automatic do_flush();
        drive_idle();
        if2.commit_feedback_pack.enable = 1'b1;
        if2.commit_feedback_pack.flush  = 1'b1;
        if1.commit_feedback_pack.enable = 1'b1;
        if1.commit_feedback_pack.flush  = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b00) begin
            bad++; $display("FAIL reset_valid2 got=%b want=00", if2.alu_fifo_data_out_valid);
        end
        rst = 1'b1;
        model_clear();
        step();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b00) begin
            bad++; $display("FAIL idle_valid2 got=%b want=00", if2.alu_fifo_data_out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (if2.alu_fifo_data_out[i] !== '0) begin
                bad++; $display("FAIL idle_data2[%0d] got=%h want=0", i, if2.alu_fifo_data_out[i]);
            end
        end
        total++;
        if (if2.issue_alu_full !== 1'b0) begin
            bad++; $display("FAIL idle_full2 got=%b want=0", if2.issue_alu_full);
        end
        total++;
        if (if1.alu_fifo_data_out_valid !== 1'b0 || if1.alu_fifo_data_out[0] !== '0
            || if1.issue_alu_full !== 1'b0) begin
            bad++; $display("FAIL idle_dut1 got valid=%b full=%b want 0/0",
                            if1.alu_fifo_data_out_valid, if1.issue_alu_full);
        end
    endtask

    task automatic test_round_robin();
        do_flush();
        for (int k = 1; k <= 4; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(k);
            step();
        end
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b11 || if2.alu_fifo_data_out[0].rob_id !== 6'd1
            || if2.alu_fifo_data_out[1].rob_id !== 6'd2) begin
            bad++; $display("FAIL rr_first got v=%b rob0=%0d rob1=%0d want v=11 1/2",
                            if2.alu_fifo_data_out_valid, if2.alu_fifo_data_out[0].rob_id,
                            if2.alu_fifo_data_out[1].rob_id);
        end
        if2.alu_fifo_pop = 2'b11;
        step();
        total++;
        if (if2.alu_fifo_data_out[0].rob_id !== 6'd3 || if2.alu_fifo_data_out[1].rob_id !== 6'd4) begin
            bad++; $display("FAIL rr_second got rob0=%0d rob1=%0d want 3/4",
                            if2.alu_fifo_data_out[0].rob_id, if2.alu_fifo_data_out[1].rob_id);
        end
        step();
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b00) begin
            bad++; $display("FAIL rr_drained got=%b want=00", if2.alu_fifo_data_out_valid);
        end
        if2.issue_alu_we      = 1'b1;
        if2.issue_alu_data_in = mk(5);
        step();
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b01 || if2.alu_fifo_data_out[0].rob_id !== 6'd5) begin
            bad++; $display("FAIL rr_wraps_to0 got v=%b rob0=%0d want v=01 rob0=5",
                            if2.alu_fifo_data_out_valid, if2.alu_fifo_data_out[0].rob_id);
        end
    endtask

    // Pops both FIFOs until empty, checking heads against the model.
    task automatic drain2(input string tag, output int cnt0, output int cnt1, output int last0);
        int cyc;
        cnt0 = 0; cnt1 = 0; last0 = -1; cyc = 0;
        while (if2.alu_fifo_data_out_valid !== 2'b00 && cyc < 12) begin
            for (int i = 0; i < 2; i++) begin
                if (m2_q[i].size() > 0) begin
                    total++;
                    if (if2.alu_fifo_data_out[i] !== m2_q[i][0]) begin
                        bad++; $display("FAIL %s_head%0d got=%0d want=%0d", tag, i,
                                        if2.alu_fifo_data_out[i].rob_id, m2_q[i][0].rob_id);
                    end
                end
            end
            if (if2.alu_fifo_data_out_valid[0]) last0 = int'(if2.alu_fifo_data_out[0].rob_id);
            cnt0 += int'(if2.alu_fifo_data_out_valid[0]);
            cnt1 += int'(if2.alu_fifo_data_out_valid[1]);
            if2.alu_fifo_pop = if2.alu_fifo_data_out_valid;
            step();
            cyc++;
        end
        drive_idle();
        total++;
        if (cyc >= 12) begin
            bad++; $display("FAIL %s_drain_timeout got valid=%b want=00", tag, if2.alu_fifo_data_out_valid);
        end
    endtask

    task automatic test_skip_full();
        int c0, c1, l0;
        do_flush();
        if2.alu_fifo_pop = 2'b10;
        for (int k = 0; k < 7; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(10 + k);
            step();
        end
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b01 || if2.alu_fifo_data_out[0].rob_id !== 6'd10
            || if2.issue_alu_full !== 1'b0) begin
            bad++; $display("FAIL skip_setup got v=%b rob0=%0d full=%b want v=01 rob0=10 full=0",
                            if2.alu_fifo_data_out_valid, if2.alu_fifo_data_out[0].rob_id, if2.issue_alu_full);
        end
        for (int k = 0; k < 3; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(20 + k);
            step();
        end
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b11 || if2.alu_fifo_data_out[1].rob_id !== 6'd20
            || if2.issue_alu_full !== 1'b0) begin
            bad++; $display("FAIL skip_to1 got v=%b rob1=%0d full=%b want v=11 rob1=20 full=0",
                            if2.alu_fifo_data_out_valid, if2.alu_fifo_data_out[1].rob_id, if2.issue_alu_full);
        end
        if2.issue_alu_we      = 1'b1;
        if2.issue_alu_data_in = mk(23);
        step();
        total++;
        if (if2.issue_alu_full !== 1'b1) begin
            bad++; $display("FAIL skip_full_set got=%b want=1", if2.issue_alu_full);
        end
        if2.issue_alu_data_in = mk(24);
        step();
        drive_idle();
        total++;
        if (if2.issue_alu_full !== 1'b1) begin
            bad++; $display("FAIL skip_full_hold got=%b want=1", if2.issue_alu_full);
        end
        drain2("skip", c0, c1, l0);
        total++;
        if (c0 != 4 || c1 != 4) begin
            bad++; $display("FAIL skip_counts got=%0d/%0d want=4/4", c0, c1);
        end
    endtask

    task automatic test_push_pop_full();
        int c0, c1, l0;
        do_flush();
        for (int k = 0; k < 8; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(30 + k);
            step();
        end
        drive_idle();
        total++;
        if (if2.issue_alu_full !== 1'b1) begin
            bad++; $display("FAIL ppf_full got=%b want=1", if2.issue_alu_full);
        end
        if2.alu_fifo_pop      = 2'b01;
        if2.issue_alu_we      = 1'b1;
        if2.issue_alu_data_in = mk(40);
        step();
        drive_idle();
        total++;
        if (if2.issue_alu_full !== 1'b0 || if2.alu_fifo_data_out[0].rob_id !== 6'd32) begin
            bad++; $display("FAIL ppf_reject got full=%b rob0=%0d want full=0 rob0=32",
                            if2.issue_alu_full, if2.alu_fifo_data_out[0].rob_id);
        end
        if2.issue_alu_we      = 1'b1;
        if2.issue_alu_data_in = mk(41);
        step();
        drive_idle();
        total++;
        if (if2.issue_alu_full !== 1'b1) begin
            bad++; $display("FAIL ppf_refill got=%b want=1", if2.issue_alu_full);
        end
        drain2("ppf", c0, c1, l0);
        total++;
        if (c0 != 4 || c1 != 4 || l0 != 41) begin
            bad++; $display("FAIL ppf_tail got cnt=%0d/%0d last0=%0d want 4/4 last0=41", c0, c1, l0);
        end
    endtask

    task automatic test_flush();
        do_flush();
        for (int k = 0; k < 3; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(50 + k);
            step();
        end
        if2.issue_alu_data_in           = mk(53);
        if2.alu_fifo_pop                = 2'b01;
        if2.commit_feedback_pack.enable = 1'b1;
        if2.commit_feedback_pack.flush  = 1'b1;
        step();
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b00 || if2.issue_alu_full !== 1'b0
            || if2.alu_fifo_data_out[0] !== '0) begin
            bad++; $display("FAIL flush_clear got v=%b full=%b want v=00 full=0",
                            if2.alu_fifo_data_out_valid, if2.issue_alu_full);
        end
        if2.issue_alu_we      = 1'b1;
        if2.issue_alu_data_in = mk(54);
        step();
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b01 || if2.alu_fifo_data_out[0].rob_id !== 6'd54) begin
            bad++; $display("FAIL flush_next got v=%b rob0=%0d want v=01 rob0=54",
                            if2.alu_fifo_data_out_valid, if2.alu_fifo_data_out[0].rob_id);
        end
        do_flush();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            if2.issue_alu_we      = 1'b1;
            if2.issue_alu_data_in = mk(60 + k);
            step();
        end
        drive_idle();
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b11) begin
            bad++; $display("FAIL areset_pre got=%b want=11", if2.alu_fifo_data_out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (if2.alu_fifo_data_out_valid !== 2'b00 || if2.alu_fifo_data_out[1] !== '0) begin
            bad++; $display("FAIL areset_now got=%b want=00", if2.alu_fifo_data_out_valid);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_order_wrap();
        do_flush();
        for (int k = 0; k < 10; k++) begin
            if1.issue_alu_we      = 1'b1;
            if1.issue_alu_data_in = mk(k);
            if1.alu_fifo_pop      = (k > 0);
            step();
            total++;
            if (if1.alu_fifo_data_out_valid !== 1'b1 || if1.alu_fifo_data_out[0].rob_id !== ROB_ID_W'(k)
                || if1.issue_alu_full !== 1'b0) begin
                bad++; $display("FAIL wrap_head%0d got v=%b rob=%0d want v=1 rob=%0d",
                                k, if1.alu_fifo_data_out_valid, if1.alu_fifo_data_out[0].rob_id, k);
            end
        end
        if1.issue_alu_we = 1'b0;
        if1.alu_fifo_pop = 1'b1;
        step();
        drive_idle();
        total++;
        if (if1.alu_fifo_data_out_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_empty got=%b want=0", if1.alu_fifo_data_out_valid);
        end
    endtask

    task automatic test_random();
        bit ev, exp_v;
        issue_execute_pack_t exp_d;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                exp_v = (m2_q[i].size() != 0);
                exp_d = exp_v ? m2_q[i][0] : '0;
                total++;
                if (if2.alu_fifo_data_out_valid[i] !== exp_v || if2.alu_fifo_data_out[i] !== exp_d) begin
                    bad++; $display("FAIL rnd_head%0d c=%0d got v=%b rob=%0d want v=%b rob=%0d", i, c,
                                    if2.alu_fifo_data_out_valid[i], if2.alu_fifo_data_out[i].rob_id,
                                    exp_v, exp_d.rob_id);
                end
            end
            ev = (m2_q[0].size() == DEPTH) && (m2_q[1].size() == DEPTH);
            total++;
            if (if2.issue_alu_full !== ev) begin
                bad++; $display("FAIL rnd_full2 c=%0d got=%b want=%b", c, if2.issue_alu_full, ev);
            end
            exp_v = (m1_q.size() != 0);
            exp_d = exp_v ? m1_q[0] : '0;
            total++;
            if (if1.alu_fifo_data_out_valid[0] !== exp_v || if1.alu_fifo_data_out[0] !== exp_d
                || if1.issue_alu_full !== (m1_q.size() == DEPTH)) begin
                bad++; $display("FAIL rnd_dut1 c=%0d got v=%b rob=%0d full=%b want v=%b rob=%0d", c,
                                if1.alu_fifo_data_out_valid[0], if1.alu_fifo_data_out[0].rob_id,
                                if1.issue_alu_full, exp_v, exp_d.rob_id);
            end
            if2.issue_alu_we                = ($urandom_range(0, 3) != 0);
            if2.issue_alu_data_in           = mk(int'($urandom_range(0, 63)));
            if2.alu_fifo_pop                = 2'($urandom_range(0, 3));
            if2.commit_feedback_pack.enable = ($urandom_range(0, 1) != 0);
            if2.commit_feedback_pack.flush  = ($urandom_range(0, 29) == 0);
            if1.issue_alu_we                = ($urandom_range(0, 2) != 0);
            if1.issue_alu_data_in           = mk(int'($urandom_range(0, 63)));
            if1.alu_fifo_pop                = ($urandom_range(0, 1) != 0);
            if1.commit_feedback_pack.enable = 1'b1;
            if1.commit_feedback_pack.flush  = ($urandom_range(0, 49) == 0);
            step();
        end
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        model_clear();
        drive_idle();
        test_reset();
        test_round_robin();
        test_skip_full();
        test_push_pop_full();
        test_flush();
        test_async_reset();
        test_order_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_alu_dispatch.md
# issue_alu_dispatch

Routes ALU micro-ops from the issue stage into `ALU_NUM` per-unit input FIFOs. Each FIFO feeds one `execute_alu` instance. The target FIFO is picked round-robin, skipping full FIFOs. The block sits between the issue stage and the ALU execute units, provides the `issue_alu_fifo_data_out`/`_valid`/`_pop` handshake each ALU consumes, and discards all buffered work on a commit flush.

## Interface
- `ALU_NUM`, default 2: number of ALU units/FIFOs, ≥1.
- `FIFO_DEPTH`, default 4: entries per FIFO, power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `issue_alu_data_in` in `issue_execute_pack_t`: op from issue.
- `issue_alu_we` in 1: issue offers `issue_alu_data_in` this cycle.
- `issue_alu_full` out 1: no FIFO can accept; issue must hold.
- `commit_feedback_pack` in `commit_feedback_pack_t`: flush = `enable && flush`.
- `alu_fifo_data_out[ALU_NUM]` out `issue_execute_pack_t`: head entry per ALU.
- `alu_fifo_data_out_valid[ALU_NUM]` out 1 each: head valid.
- `alu_fifo_pop[ALU_NUM]` in 1 each: ALU consumed head.

## Operation
- State per FIFO `i`: storage `[FIFO_DEPTH]`, `rptr`/`wptr` of `$clog2(FIFO_DEPTH)` bits wrapping modulo depth, and `count` of `$clog2(FIFO_DEPTH+1)` bits. Global state: `rr_ptr` of `$clog2(ALU_NUM)` bits (1 bit when `ALU_NUM==1`, held at 0).
- `full[i] = (count[i]==FIFO_DEPTH)`, computed from registered count only. A same-cycle pop does not free a slot for a push into that FIFO.
- Target: the first `i` scanning `rr_ptr, rr_ptr+1, …` (mod `ALU_NUM`) with `!full[i]`. `issue_alu_full = &full`.
- Accept when `issue_alu_we && !issue_alu_full && !flush`. On accept, write `storage[target][wptr]`, then `wptr++`, then set `rr_ptr = (target+1) mod ALU_NUM`.
- Pop: `alu_fifo_pop[i] && count[i]!=0 && !flush` gives `rptr++`. A pop on an empty FIFO is ignored.
- Count update per FIFO: +1 on push only, −1 on pop only, unchanged on both or neither.
- `alu_fifo_data_out_valid[i] = (count[i]!=0)`. `alu_fifo_data_out[i] = storage[i][rptr[i]]` when valid, else all-zero.
- Flush has priority over everything. All counts and pointers go to 0 and `rr_ptr` goes to 0. The write and pops in that cycle are dropped.
- No reordering within a FIFO. There is no ordering guarantee across FIFOs; the ROB handles ordering.

## Timing
- Reset: counts, `rptr`, `wptr` and `rr_ptr` are 0, so all `alu_fifo_data_out_valid` = 0, all `alu_fifo_data_out` = 0 and `issue_alu_full` = 0. Storage is not reset.
- Reset asserted mid-operation clears state immediately and asynchronously. Buffered ops are lost.
- Latency: an op accepted in cycle N appears at its FIFO head with valid=1 in cycle N+1 at the earliest.
- Throughput: 1 accept per cycle; up to `ALU_NUM` pops per cycle.
- `issue_alu_full` is combinational from registered counts. It does not depend on `issue_alu_we` or pops, so there is no combinational loop with issue or ALU.
- Flush in cycle N: all outputs valid=0 in cycle N+1. An accept is possible again in cycle N+1.

## Structure
- No new package types; use `issue_execute_pack_t` and `commit_feedback_pack_t` from `common.svh`.
- Sub-module `issue_alu_fifo`:
  - Parameters: `DEPTH`.
  - Ports: push/pop/flush, data, count.
  - Instantiate `ALU_NUM` times via generate.
  - Round-robin selection and `rr_ptr` live in the top module.

## Test plan
- **Reset/idle:** deassert `rst`, no writes → all valid=0, all data_out=0, `issue_alu_full`=0.
- **Round-robin:** `ALU_NUM=2`, no pops, write ops with rob_id 1,2,3,4 → FIFO0 heads rob 1 then 3, FIFO1 heads rob 2 then 4, `rr_ptr` ends at 0.
- **Skip-full:**
  - Fill FIFO0 with 4 entries and keep it unpopped; FIFO1 empty.
  - Write 3 ops → all go to FIFO1, `issue_alu_full`=0.
  - A 4th write fills FIFO1 → `issue_alu_full`=1 the next cycle, and a write while full leaves counts at 4/4.
- **Simultaneous push/pop on full FIFO:** all FIFOs full, pop FIFO0 and write in the same cycle → write rejected, FIFO0 count=3. The next cycle's write goes to FIFO0.
- **Flush:**
  - Stage 3 ops, then assert commit enable+flush together with `issue_alu_we` and `alu_fifo_pop[0]`.
  - Next cycle: all valid=0, `rr_ptr`=0.
  - The next write lands in FIFO0.
- **FIFO order and wrap:** stream 10 ops into FIFO0 (`ALU_NUM=1`) with pop every cycle after the first → heads appear in rob_id order 0..9 across pointer wrap, with no bubbles after the first.
